id_ex_issue: RTL and testbench

// - ID/EX issue stage: registers one decoded instruction and drives the alu operand interface (op1, op2, aluop).
// - Resolves operand bypass from the EX/MEM and MEM/WB stages and detects load-use hazards.
// - Uses valid/ready handshakes on both sides, so decode and the ALU stage can stall independently.

---
 rtl/id_ex_issue.sv | 162 ++++++++++++++++
 tb/tb_id_ex_issue.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_issue.sv
// ID/EX issue stage: holds one decoded instruction and presents ALU operands with valid/ready on both sides.
// Optional macro FWD_EN enables the EX/MEM + MEM/WB bypass network, WB snoop and load-use stall.
module id_ex_issue #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [AW-1:0]   id_rs1,
  input  logic [AW-1:0]   id_rs2,
  input  logic [AW-1:0]   id_rd,
  input  logic            id_op1_pc,
  input  logic            id_op2_imm,
  input  logic [3:0]      id_aluop,
  input  logic            mem_wen,
  input  logic            mem_load,
  input  logic [AW-1:0]   mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            wb_wen,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output logic [3:0]      aluop,
  output logic [AW-1:0]   ex_rd
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [XLEN-1:0] pc_r, rs1_data_r, rs2_data_r, imm_r;
  logic [AW-1:0]   rs1_r, rs2_r, rd_r;
  logic            op1_pc_r, op2_imm_r;
  logic [3:0]      aluop_r;
  logic [XLEN-1:0] op1_src_s, op2_src_s;
  logic            hazard_s, capture_s, consume_s;

`ifdef FWD_EN
  function automatic logic [XLEN-1:0] bypass_f(
    input logic [AW-1:0]   rs,
    input logic [XLEN-1:0] held,
    input logic            m_wen,
    input logic            m_load,
    input logic [AW-1:0]   m_rd,
    input logic [XLEN-1:0] m_data,
    input logic            w_wen,
    input logic [AW-1:0]   w_rd,
    input logic [XLEN-1:0] w_data
  );
    if (rs == {AW{1'b0}}) begin
      return {XLEN{1'b0}};
    end else if (m_wen && !m_load && (m_rd == rs)) begin
      return m_data;
    end else if (w_wen && (w_rd == rs)) begin
      return w_data;
    end else begin
      return held;
    end
  endfunction

  assign op1_src_s = bypass_f(rs1_r, rs1_data_r, mem_wen, mem_load, mem_rd, mem_data,
                              wb_wen, wb_rd, wb_data);
  assign op2_src_s = bypass_f(rs2_r, rs2_data_r, mem_wen, mem_load, mem_rd, mem_data,
                              wb_wen, wb_rd, wb_data);
  // A load still in EX/MEM cannot be bypassed; hold the instruction until it reaches WB.
  assign hazard_s  = (state_r == FULL) && mem_load && mem_wen && (mem_rd != {AW{1'b0}}) &&
                     ((!op1_pc_r && (mem_rd == rs1_r)) || (!op2_imm_r && (mem_rd == rs2_r)));
`else
  logic unused_fwd_s;
  assign op1_src_s    = rs1_data_r;
  assign op2_src_s    = rs2_data_r;
  assign hazard_s     = 1'b0;
  assign unused_fwd_s = ^{mem_wen, mem_load, mem_rd, mem_data, wb_wen, wb_rd, wb_data,
                          rs1_r, rs2_r};
`endif

  assign ex_valid  = (state_r == FULL) && !hazard_s;
  assign id_ready  = rst_n && !flush &&
                     ((state_r == EMPTY) || ((state_r == FULL) && ex_ready && !hazard_s));
  assign capture_s = id_valid && id_ready;
  assign consume_s = ex_valid && ex_ready;
  assign op1       = op1_pc_r ? pc_r : op1_src_s;
  assign op2       = op2_imm_r ? imm_r : op2_src_s;
  assign aluop     = aluop_r;
  assign ex_rd     = rd_r;

  // Next-state logic for the hold/issue/stall controller.
  always_comb begin
    state_nxt_s = state_r;
    if (flush) begin
      state_nxt_s = EMPTY;
    end else begin
      case (state_r)
        EMPTY: begin
          if (capture_s) state_nxt_s = FULL;
          else           state_nxt_s = EMPTY;
        end
        FULL: begin
          if (hazard_s)       state_nxt_s = STALL;
          else if (consume_s) state_nxt_s = capture_s ? FULL : EMPTY;
          else                state_nxt_s = FULL;
        end
        STALL:   state_nxt_s = FULL;
        default: state_nxt_s = EMPTY;
      endcase
    end
  end

  // State register and held instruction fields, with WB snoop of the held operands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= EMPTY;
      pc_r       <= {XLEN{1'b0}};
      rs1_data_r <= {XLEN{1'b0}};
      rs2_data_r <= {XLEN{1'b0}};
      imm_r      <= {XLEN{1'b0}};
      rs1_r      <= {AW{1'b0}};
      rs2_r      <= {AW{1'b0}};
      rd_r       <= {AW{1'b0}};
      op1_pc_r   <= 1'b0;
      op2_imm_r  <= 1'b0;
      aluop_r    <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      if (capture_s) begin
        pc_r       <= id_pc;
        rs1_data_r <= id_rs1_data;
        rs2_data_r <= id_rs2_data;
        imm_r      <= id_imm;
        rs1_r      <= id_rs1;
        rs2_r      <= id_rs2;
        rd_r       <= id_rd;
        op1_pc_r   <= id_op1_pc;
        op2_imm_r  <= id_op2_imm;
        aluop_r    <= id_aluop;
      end else begin
`ifdef FWD_EN
        if ((state_r != EMPTY) && wb_wen && (wb_rd == rs1_r) && (rs1_r != {AW{1'b0}})) begin
          rs1_data_r <= wb_data;
        end
        if ((state_r != EMPTY) && wb_wen && (wb_rd == rs2_r) && (rs2_r != {AW{1'b0}})) begin
          rs2_data_r <= wb_data;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_id_ex_issue.sv
// Directed self-checking bench for id_ex_issue; expectations follow whether FWD_EN is defined.
module tb_id_ex_issue;

`ifdef FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, flush, id_valid, id_ready;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_op1_pc, id_op2_imm;
  logic [3:0]  id_aluop;
  logic        mem_wen, mem_load, wb_wen;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_data, wb_data;
  logic        ex_valid, ex_ready;
  logic [31:0] op1, op2;
  logic [3:0]  aluop;
  logic [4:0]  ex_rd;

  int n_checks = 0;
  int n_errors = 0;

  id_ex_issue #(.XLEN(32), .AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_op1_pc(id_op1_pc), .id_op2_imm(id_op2_imm), .id_aluop(id_aluop),
    .mem_wen(mem_wen), .mem_load(mem_load), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .op1(op1), .op2(op2), .aluop(aluop), .ex_rd(ex_rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_instr(input logic [31:0] pc, input logic [4:0] rs1, input logic [31:0] d1,
                             input logic [4:0] rs2, input logic [31:0] d2, input logic [31:0] imm,
                             input logic [4:0] rd, input logic o1pc, input logic o2imm,
                             input logic [3:0] op);
    id_valid = 1'b1; id_pc = pc; id_rs1 = rs1; id_rs1_data = d1; id_rs2 = rs2;
    id_rs2_data = d2; id_imm = imm; id_rd = rd; id_op1_pc = o1pc; id_op2_imm = o2imm;
    id_aluop = op;
  endtask

  task automatic clear_fwd();
    mem_wen = 1'b0; mem_load = 1'b0; mem_rd = 5'd0; mem_data = 32'd0;
    wb_wen = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; ex_ready = 1'b0;
    drive_instr(32'h4, 5'd1, 32'h9, 5'd2, 32'h9, 32'h9, 5'd3, 1'b0, 1'b0, 4'd7);
    clear_fwd();

    // Reset with id_valid held high
    next_cycle(); #2;
    check("rst_ex_valid", 32'(ex_valid), 32'd0);
    check("rst_op1", op1, 32'd0);
    check("rst_op2", op2, 32'd0);
    check("rst_id_ready", 32'(id_ready), 32'd0);
    check("rst_aluop", 32'(aluop), 32'd0);
    check("rst_ex_rd", 32'(ex_rd), 32'd0);
    next_cycle();
    check("rst_id_ready2", 32'(id_ready), 32'd0);
    rst_n = 1'b1; id_valid = 1'b0;

    // Back-to-back issue, no bubbles
    ex_ready = 1'b1;
    drive_instr(32'h10, 5'd1, 32'd5, 5'd2, 32'd9, 32'd7, 5'd10, 1'b0, 1'b1, 4'd1);
    #2;
    check("b2b_ready0", 32'(id_ready), 32'd1);
    check("b2b_valid0", 32'(ex_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      if (i < 2) drive_instr(32'h14, 5'd1, 32'd5, 5'd2, 32'd9, 32'd7, 5'(11 + i), 1'b0, 1'b1, 4'(2 + i));
      else       id_valid = 1'b0;
      #2;
      check("b2b_valid", 32'(ex_valid), 32'd1);
      check("b2b_op1", op1, 32'd5);
      check("b2b_op2", op2, 32'd7);
      check("b2b_aluop", 32'(aluop), 32'(1 + i));
      check("b2b_ex_rd", 32'(ex_rd), 32'(10 + i));
      check("b2b_ready", 32'(id_ready), 32'd1);
    end
    next_cycle(); #2;
    check("b2b_drain", 32'(ex_valid), 32'd0);
    check("b2b_hold_aluop", 32'(aluop), 32'd3);

    // Bypass priority on op1
    ex_ready = 1'b0;
    drive_instr(32'h20, 5'd3, 32'h1, 5'd0, 32'h0, 32'h0, 5'd5, 1'b0, 1'b1, 4'd4);
    next_cycle();
    id_valid = 1'b0;
    mem_wen = 1'b1; mem_rd = 5'd3; mem_data = 32'hA;
    wb_wen = 1'b1; wb_rd = 5'd3; wb_data = 32'hB;
    #2;
    check("byp_valid", 32'(ex_valid), 32'd1);
    check("byp_mem", op1, FWD ? 32'hA : 32'h1);
    next_cycle();
    mem_wen = 1'b0;
    #2;
    check("byp_wb", op1, FWD ? 32'hB : 32'h1);
    next_cycle();
    wb_wen = 1'b0;
    #2;
    check("byp_snoop_hold", op1, FWD ? 32'hB : 32'h1);
    ex_ready = 1'b1;
    drive_instr(32'h30, 5'd0, 32'h1, 5'd0, 32'h0, 32'h0, 5'd6, 1'b0, 1'b1, 4'd5);
    #2;
    check("byp_replace_ready", 32'(id_ready), 32'd1);
    next_cycle();
    id_valid = 1'b0; ex_ready = 1'b0;
    mem_wen = 1'b1; mem_rd = 5'd0; mem_data = 32'hA;
    wb_wen = 1'b1; wb_rd = 5'd0; wb_data = 32'hB;
    #2;
    check("byp_x0", op1, FWD ? 32'h0 : 32'h1);
    check("byp_x0_aluop", 32'(aluop), 32'd5);
    next_cycle();
    clear_fwd(); ex_ready = 1'b1;
    next_cycle(); #2;
    check("byp_drain", 32'(ex_valid), 32'd0);

    // Load-use on rs2
    drive_instr(32'h40, 5'd0, 32'h0, 5'd4, 32'h11, 32'h99, 5'd8, 1'b0, 1'b0, 4'd6);
    next_cycle();
    id_valid = 1'b0;
    mem_load = 1'b1; mem_wen = 1'b1; mem_rd = 5'd4; mem_data = 32'h77;
    #2;
    check("lu_hazard_valid", 32'(ex_valid), FWD ? 32'd0 : 32'd1);
    check("lu_hazard_op2", op2, 32'h11);
    check("lu_hazard_ready", 32'(id_ready), FWD ? 32'd0 : 32'd1);
    next_cycle();
    clear_fwd();
    wb_wen = 1'b1; wb_rd = 5'd4; wb_data = 32'h55;
    #2;
    check("lu_stall_valid", 32'(ex_valid), 32'd0);
    next_cycle();
    wb_wen = 1'b0;
    #2;
    check("lu_resume_valid", 32'(ex_valid), FWD ? 32'd1 : 32'd0);
    check("lu_resume_op2", op2, FWD ? 32'h55 : 32'h11);
    check("lu_resume_rd", 32'(ex_rd), 32'd8);
    next_cycle(); #2;
    check("lu_drain", 32'(ex_valid), 32'd0);

    // Backpressure then flush
    ex_ready = 1'b0;
    drive_instr(32'h100, 5'd0, 32'h0, 5'd6, 32'h33, 32'h0, 5'd7, 1'b1, 1'b0, 4'd9);
    next_cycle();
    drive_instr(32'h200, 5'd1, 32'hEE, 5'd2, 32'hDD, 32'h1, 5'd2, 1'b0, 1'b1, 4'd3);
    for (int i = 0; i < 3; i++) begin
      #2;
      check("bp_id_ready", 32'(id_ready), 32'd0);
      check("bp_valid", 32'(ex_valid), 32'd1);
      check("bp_op1", op1, 32'h100);
      check("bp_op2", op2, 32'h33);
      check("bp_aluop", 32'(aluop), 32'd9);
      check("bp_ex_rd", 32'(ex_rd), 32'd7);
      next_cycle();
    end
    flush = 1'b1;
    #2;
    check("fl_id_ready", 32'(id_ready), 32'd0);
    next_cycle();
    flush = 1'b0; id_valid = 1'b0;
    #2;
    check("fl_valid", 32'(ex_valid), 32'd0);
    check("fl_no_capture_op1", op1, 32'h100);
    check("fl_no_capture_rd", 32'(ex_rd), 32'd7);
    check("fl_empty_ready", 32'(id_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
